// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types for the multi-channel clock-gating controller.
package clk_gate_ctrl_pkg;

    localparam int WCNT_W = 4;

    typedef logic [1:0] ch_state_t;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } ch_state_e;

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based integrated clock gate: enable is captured while CLK is low,
// so GCLK can only start or stop on a CLK rising edge.
module clk_gate_cell (
    input  logic CLK,
    input  logic RN,
    input  logic EN,
    input  logic TE,
    output logic GCLK
);

    logic r_latch_q;

    always_latch begin
        if (!RN) begin
            r_latch_q <= 1'b0;
        end else if (!CLK) begin
            r_latch_q <= EN | TE;
        end
    end

    assign GCLK = CLK & r_latch_q;

endmodule

// File: rtl/clk_gate_ctrl_multi.sv
// Multi-channel clock-gating controller: per-channel wake/hold FSM with
// REQ/ACK handshake, software force-on and a global test-enable override.
module clk_gate_ctrl_multi
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             TE,
    input  logic [NCH-1:0]   REQ,
    input  logic [NCH-1:0]   SW_EN,
    input  logic [CNT_W-1:0] IDLE_LIM,
    output logic [NCH-1:0]   GCLK,
    output logic [NCH-1:0]   ACK,
    output logic [NCH-1:0]   CH_ON
);

    localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_CYC - 1);

    // First stage of the reset-release synchroniser; the FSM registers form
    // the second stage, so the first state update lands on the 2nd edge.
    logic r_rst_sync;
    logic w_run;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
        end
    end

    assign w_run = r_rst_sync;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ch_state_e          r_state;
        ch_state_e          w_state_nxt;
        logic [WCNT_W-1:0]  r_wcnt;
        logic [WCNT_W-1:0]  w_wcnt_nxt;
        logic [CNT_W-1:0]   r_hcnt;
        logic [CNT_W-1:0]   w_hcnt_nxt;
        logic               r_en;
        logic               r_ack;
        logic               w_want;

        assign w_want = REQ[gi] | SW_EN[gi];

        always_comb begin
            w_state_nxt = r_state;
            w_wcnt_nxt  = r_wcnt;
            w_hcnt_nxt  = r_hcnt;
            case (r_state)
                ST_OFF: begin
                    if (w_want) begin
                        w_state_nxt = ST_WAKE;
                        w_wcnt_nxt  = WAKE_LOAD;
                    end
                end
                // A dropped request cannot abort the wake-up window.
                ST_WAKE: begin
                    if (r_wcnt == '0) begin
                        w_state_nxt = ST_ON;
                    end else begin
                        w_wcnt_nxt = r_wcnt - 1'b1;
                    end
                end
                ST_ON: begin
                    if (!w_want) begin
                        if (IDLE_LIM == '0) begin
                            w_state_nxt = ST_OFF;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_hcnt_nxt  = IDLE_LIM - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_want) begin
                        w_state_nxt = ST_ON;
                    end else if (r_hcnt == '0) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_hcnt_nxt = r_hcnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end

        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                r_state <= ST_OFF;
                r_wcnt  <= '0;
                r_hcnt  <= '0;
                r_en    <= 1'b0;
                r_ack   <= 1'b0;
            end else if (w_run) begin
                r_state <= w_state_nxt;
                r_wcnt  <= w_wcnt_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_en    <= (w_state_nxt != ST_OFF);
                r_ack   <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);
            end
        end

        assign CH_ON[gi] = r_en;
        assign ACK[gi]   = r_ack;

        clk_gate_cell u_cell (
            .CLK  (CLK),
            .RN   (RN),
            .EN   (r_en),
            .TE   (TE),
            .GCLK (GCLK[gi])
        );
    end

endmodule

// File: tb/tb_clk_gate_ctrl_multi.sv
// Bench for clk_gate_ctrl_multi: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural channel model.
module tb_clk_gate_ctrl_multi;

    localparam int NCH      = 4;
    localparam int CNT_W    = 8;
    localparam int WAKE_CYC = 2;
    localparam int HALF     = 5;
    localparam int PERIOD   = 2 * HALF;

    logic             CLK = 1'b0;
    logic             RN  = 1'b0;
    logic             TE  = 1'b0;
    logic [NCH-1:0]   REQ = '0;
    logic [NCH-1:0]   SW_EN = '0;
    logic [CNT_W-1:0] IDLE_LIM = '0;
    logic [NCH-1:0]   GCLK;
    logic [NCH-1:0]   ACK;
    logic [NCH-1:0]   CH_ON;

    int total = 0;
    int bad   = 0;

    always #HALF CLK = ~CLK;

    clk_gate_ctrl_multi #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .TE       (TE),
        .REQ      (REQ),
        .SW_EN    (SW_EN),
        .IDLE_LIM (IDLE_LIM),
        .GCLK     (GCLK),
        .ACK      (ACK),
        .CH_ON    (CH_ON)
    );

    // ---------------- behavioural reference model ----------------
    // Each channel is described by: is the clock enabled, is it acknowledged,
    // how many wake cycles remain, and how long want has been low in a row.
    logic [NCH-1:0] m_en;
    logic [NCH-1:0] m_ack;
    logic [NCH-1:0] m_gate;
    int             m_wake_left [NCH];
    int             m_idle_run  [NCH];
    int             m_idle_lim  [NCH];
    int             m_rel_edges;

    function automatic void model_reset();
        m_en   = '0;
        m_ack  = '0;
        m_gate = '0;
        m_rel_edges = 0;
        for (int i = 0; i < NCH; i++) begin
            m_wake_left[i] = 0;
            m_idle_run[i]  = 0;
            m_idle_lim[i]  = 0;
        end
    endfunction

    function automatic void model_step();
        logic want;
        if (!RN) begin
            model_reset();
            return;
        end
        if (m_rel_edges < 10) m_rel_edges++;
        m_gate = m_en | {NCH{TE}};
        if (m_rel_edges < 2) return;
        for (int i = 0; i < NCH; i++) begin
            want = REQ[i] | SW_EN[i];
            if (!m_en[i]) begin
                if (want) begin
                    m_en[i] = 1'b1;
                    m_wake_left[i] = WAKE_CYC;
                end
            end else if (m_wake_left[i] > 0) begin
                m_wake_left[i]--;
                if (m_wake_left[i] == 0) begin
                    m_ack[i] = 1'b1;
                    m_idle_run[i] = 0;
                end
            end else if (want) begin
                m_idle_run[i] = 0;
            end else begin
                if (m_idle_run[i] == 0) m_idle_lim[i] = int'(IDLE_LIM);
                m_idle_run[i]++;
                if (m_idle_run[i] > m_idle_lim[i]) begin
                    m_en[i]  = 1'b0;
                    m_ack[i] = 1'b0;
                    m_idle_run[i] = 0;
                end
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Entered in the CLK high phase; inputs are applied, one rising edge is
    // taken, and outputs are compared in the following high phase.
    task automatic step(input logic [NCH-1:0] req, input logic [NCH-1:0] sw,
                        input logic te, input logic [CNT_W-1:0] lim);
        REQ = req;
        SW_EN = sw;
        TE = te;
        IDLE_LIM = lim;
        @(posedge CLK);
        model_step();
        #3;
        chk("model_ch_on", CH_ON, m_en);
        chk("model_ack", ACK, m_ack);
        chk("model_gclk", GCLK, m_gate);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0);
    endtask

    // ---------------- GCLK pulse-width monitor ----------------
    logic [NCH-1:0] g_prev = '0;
    time            t_rise [NCH];

    always @(GCLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (GCLK[i] === 1'b1 && g_prev[i] !== 1'b1) begin
                t_rise[i] = $time;
            end else if (GCLK[i] === 1'b0 && g_prev[i] === 1'b1 && RN === 1'b1) begin
                total++;
                if (($time - t_rise[i]) != HALF || (t_rise[i] % PERIOD) != HALF) begin
                    bad++;
                    $display("FAIL pulse_width ch%0d: rise=%0t fall=%0t expected width %0d on CLK high",
                             i, t_rise[i], $time, HALF);
                end
            end
        end
        g_prev = GCLK;
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NCH-1:0]   req;
        logic [NCH-1:0]   sw;
        logic             te;
        logic [CNT_W-1:0] lim;
        logic [NCH-1:0]   e_on;
        logic [NCH-1:0]   e_ack;
        logic [NCH-1:0]   e_gclk;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NCH-1:0] cur_req;
        logic [NCH-1:0] cur_sw;

        //                req      sw       te    lim    on       ack      gclk
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 8'd5, 4'b0001, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 8'd5, 4'b0001, 4'b0000, 4'b0001};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 8'd5, 4'b0001, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 8'd5, 4'b0001, 4'b0001, 4'b0001};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0001, 4'b0001, 4'b0001};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0001, 4'b0001, 4'b0001};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0001, 4'b0001, 4'b0001};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0001, 4'b0001, 4'b0001};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0001};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0100, 4'b0000, 1'b1, 8'd0, 4'b0100, 4'b0000, 4'b1111};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0100, 4'b0000, 4'b0100};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0100, 4'b0100, 4'b0100};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0100};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000};

        // Reset held with TE=1 and requests pending: everything stays low.
        model_reset();
        RN = 1'b0;
        TE = 1'b1;
        REQ = '1;
        IDLE_LIM = 8'd5;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #3;
            chk("rst_gclk_high", GCLK, 0);
            chk("rst_ack", ACK, 0);
            chk("rst_ch_on", CH_ON, 0);
            #4;
            chk("rst_gclk_low", GCLK, 0);
        end
        @(posedge CLK);
        #3;

        // Release: first FSM update on the 2nd rising edge.
        RN = 1'b1;
        step('1, '0, 1'b1, 8'd5);
        chk("rel_edge1_ch_on", CH_ON, 0);
        chk("rel_edge1_gclk_te", GCLK, 4'b1111);
        step('1, '0, 1'b1, 8'd5);
        chk("rel_edge2_ch_on", CH_ON, 4'b1111);
        idle_steps(6);

        foreach (tbl[r]) begin
            step(tbl[r].req, tbl[r].sw, tbl[r].te, tbl[r].lim);
            chk($sformatf("tbl%0d_ch_on", r), CH_ON, tbl[r].e_on);
            chk($sformatf("tbl%0d_ack", r), ACK, tbl[r].e_ack);
            chk($sformatf("tbl%0d_gclk", r), GCLK, tbl[r].e_gclk);
        end

        // Re-request during hold, IDLE_LIM=5: ACK and GCLK never drop.
        step(4'b0010, '0, 1'b0, 8'd5);
        step(4'b0010, '0, 1'b0, 8'd5);
        step(4'b0010, '0, 1'b0, 8'd5);
        chk("rereq_ack_up", ACK[1], 1);
        for (int k = 0; k < 5; k++) begin
            step((k == 3 || k == 4) ? 4'b0010 : 4'b0000, '0, 1'b0, 8'd5);
            chk($sformatf("rereq_hold%0d_ack_gclk", k), {ACK[1], GCLK[1], CH_ON[1]}, 3'b111);
        end

        // Same drop with IDLE_LIM=0: immediate OFF, then a fresh wake.
        step(4'b0000, '0, 1'b0, 8'd0);
        chk("lim0_off", {CH_ON[1], ACK[1], GCLK[1]}, 3'b001);
        step(4'b0000, '0, 1'b0, 8'd0);
        step(4'b0000, '0, 1'b0, 8'd0);
        step(4'b0010, '0, 1'b0, 8'd0);
        chk("lim0_rewake", {CH_ON[1], ACK[1], GCLK[1]}, 3'b100);
        step(4'b0010, '0, 1'b0, 8'd0);
        step(4'b0010, '0, 1'b0, 8'd0);
        chk("lim0_reack", ACK[1], 1);
        idle_steps(4);

        // Software force-on keeps channel 2 running with REQ low.
        for (int k = 0; k < 20; k++) step('0, 4'b0100, 1'b0, 8'd3);
        chk("sw_en_hold", {CH_ON, ACK, GCLK}, {4'b0100, 4'b0100, 4'b0100});
        idle_steps(8);

        // TE rising in the low phase enables every gate at the next edge.
        #4;
        TE = 1'b1;
        @(posedge CLK);
        model_step();
        #3;
        chk("te_low_phase_gclk", GCLK, 4'b1111);
        chk("te_ack_off", ACK, 0);
        step('0, '0, 1'b1, 8'd0);
        chk("te_hold_gclk", GCLK, 4'b1111);
        idle_steps(2);

        // Mid-operation reset with everything running.
        for (int k = 0; k < 4; k++) step('1, '0, 1'b0, 8'd4);
        RN = 1'b0;
        model_reset();
        #1;
        chk("midrst_outputs", {GCLK, ACK, CH_ON}, 0);
        TE = 1'b1;
        @(posedge CLK);
        #3;
        chk("midrst_te_gclk", GCLK, 0);
        RN = 1'b1;
        idle_steps(4);

        // Randomized traffic against the model.
        cur_req = '0;
        cur_sw  = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                RN = 1'b0;
                model_reset();
                #1;
                chk("rand_async_rst", {GCLK, ACK, CH_ON}, 0);
                @(posedge CLK);
                #3;
                RN = 1'b1;
            end
            cur_req ^= NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) cur_sw ^= NCH'(1 << $urandom_range(0, NCH - 1));
            #($urandom_range(0, 1));
            step(cur_req, cur_sw, ($urandom_range(0, 9) == 0), CNT_W'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
